// File: rtl/rs_alu_multi_if.sv
// Dispatch, wakeup and issue bundle for the ALU reservation station.
// The slave modport is the station side; master is the dispatch/ALU side.
interface rs_alu_multi_if #(
  parameter int unsigned ENTRIES  = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned ALUOP_W  = 4,
  parameter int unsigned WB_PORTS = 2
) ();
  logic                         flush_i;
  logic                         alloc_valid_i;
  logic                         alloc_ready_o;
  logic [ADDR_W-1:0]            alloc_pc_i;
  logic [DATA_W-1:0]            alloc_op1_i;
  logic [DATA_W-1:0]            alloc_op2_i;
  logic                         alloc_valid1_i;
  logic                         alloc_valid2_i;
  logic [DATA_W-1:0]            alloc_imm_i;
  logic [TAG_W-1:0]             alloc_rrf_tag_i;
  logic                         alloc_dst_en_i;
  logic [ALUOP_W-1:0]           alloc_alu_op_i;
  logic [WB_PORTS-1:0]          wb_valid_i;
  logic [WB_PORTS*TAG_W-1:0]    wb_tag_i;
  logic [WB_PORTS*DATA_W-1:0]   wb_data_i;
  logic                         issue_valid_o;
  logic                         issue_ready_i;
  logic [ADDR_W-1:0]            issue_pc_o;
  logic [DATA_W-1:0]            issue_op1_o;
  logic [DATA_W-1:0]            issue_op2_o;
  logic [DATA_W-1:0]            issue_imm_o;
  logic [TAG_W-1:0]             issue_rrf_tag_o;
  logic                         issue_dst_en_o;
  logic [ALUOP_W-1:0]           issue_alu_op_o;
  logic [$clog2(ENTRIES):0]     count_o;

  modport slave (
    input  flush_i, alloc_valid_i, alloc_pc_i, alloc_op1_i, alloc_op2_i,
           alloc_valid1_i, alloc_valid2_i, alloc_imm_i, alloc_rrf_tag_i,
           alloc_dst_en_i, alloc_alu_op_i, wb_valid_i, wb_tag_i, wb_data_i,
           issue_ready_i,
    output alloc_ready_o, issue_valid_o, issue_pc_o, issue_op1_o, issue_op2_o,
           issue_imm_o, issue_rrf_tag_o, issue_dst_en_o, issue_alu_op_o, count_o
  );

  modport master (
    output flush_i, alloc_valid_i, alloc_pc_i, alloc_op1_i, alloc_op2_i,
           alloc_valid1_i, alloc_valid2_i, alloc_imm_i, alloc_rrf_tag_i,
           alloc_dst_en_i, alloc_alu_op_i, wb_valid_i, wb_tag_i, wb_data_i,
           issue_ready_i,
    input  alloc_ready_o, issue_valid_o, issue_pc_o, issue_op1_o, issue_op2_o,
           issue_imm_o, issue_rrf_tag_o, issue_dst_en_o, issue_alu_op_o, count_o
  );
endinterface

// File: rtl/rs_alu_multi.sv
// Multi-entry ALU reservation station with operand wakeup and single issue.
// Define RS_ALU_AGE_SELECT_EN for oldest-first select; otherwise lowest index wins.
module rs_alu_multi #(
  parameter int unsigned ENTRIES  = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned ALUOP_W  = 4,
  parameter int unsigned WB_PORTS = 2
) (
  input logic           clk,
  input logic           reset,
  rs_alu_multi_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(ENTRIES) + 1;

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [ENTRIES-1:0] v1_q, v1_d, v2_q, v2_d;
  logic [ENTRIES-1:0] dst_en_q, dst_en_d;
  logic [ADDR_W-1:0]  pc_q     [ENTRIES];
  logic [ADDR_W-1:0]  pc_d     [ENTRIES];
  logic [DATA_W-1:0]  op1_q    [ENTRIES];
  logic [DATA_W-1:0]  op1_d    [ENTRIES];
  logic [DATA_W-1:0]  op2_q    [ENTRIES];
  logic [DATA_W-1:0]  op2_d    [ENTRIES];
  logic [DATA_W-1:0]  imm_q    [ENTRIES];
  logic [DATA_W-1:0]  imm_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ALUOP_W-1:0] alu_op_q [ENTRIES];
  logic [ALUOP_W-1:0] alu_op_d [ENTRIES];
  logic [CNT_W-1:0]   count_q, count_d;
`ifdef RS_ALU_AGE_SELECT_EN
  // age_q[i][j] set means entry j is older than entry i
  logic [ENTRIES-1:0] age_q [ENTRIES];
  logic [ENTRIES-1:0] age_d [ENTRIES];
`endif

  logic [ENTRIES-1:0] ready;
  logic [IDX_W-1:0]   sel_idx, alloc_idx;
  logic               issue_valid, alloc_ready, alloc_fire, issue_fire;

  // Lowest-numbered matching broadcast port wins; returns {hit, data}.
  function automatic logic [DATA_W:0] wb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [WB_PORTS-1:0]       wb_valid,
    input logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input logic [WB_PORTS*DATA_W-1:0] wb_data
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
      if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == tag))
        r = {1'b1, wb_data[p*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  // Free-slot search and issue select
  always_comb begin
    ready       = busy_q & v1_q & v2_q;
    issue_valid = |ready;
    alloc_ready = |(~busy_q);
    sel_idx     = '0;
    alloc_idx   = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
`ifdef RS_ALU_AGE_SELECT_EN
      if (ready[i] && ((age_q[i] & ready) == '0)) sel_idx = IDX_W'(i);
`else
      if (ready[i]) sel_idx = IDX_W'(i);
`endif
    end
    alloc_fire = bus.alloc_valid_i & alloc_ready & ~bus.flush_i;
    issue_fire = issue_valid & bus.issue_ready_i & ~bus.flush_i;
  end

  // Next-state: flush, wakeup, issue retire, allocation with bypass
  always_comb begin
    logic [DATA_W:0] lk;
    busy_d   = busy_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    dst_en_d = dst_en_q;
    pc_d     = pc_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    imm_d    = imm_q;
    tag_d    = tag_q;
    alu_op_d = alu_op_q;
    count_d  = count_q;
`ifdef RS_ALU_AGE_SELECT_EN
    age_d    = age_q;
`endif
    lk       = '0;
    if (bus.flush_i) begin
      busy_d  = '0;
      count_d = '0;
`ifdef RS_ALU_AGE_SELECT_EN
      for (int i = 0; i < int'(ENTRIES); i++) age_d[i] = '0;
`endif
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        if (busy_q[i] && !v1_q[i]) begin
          lk = wb_lookup(op1_q[i][TAG_W-1:0], bus.wb_valid_i, bus.wb_tag_i, bus.wb_data_i);
          if (lk[DATA_W]) begin
            op1_d[i] = lk[DATA_W-1:0];
            v1_d[i]  = 1'b1;
          end
        end
        if (busy_q[i] && !v2_q[i]) begin
          lk = wb_lookup(op2_q[i][TAG_W-1:0], bus.wb_valid_i, bus.wb_tag_i, bus.wb_data_i);
          if (lk[DATA_W]) begin
            op2_d[i] = lk[DATA_W-1:0];
            v2_d[i]  = 1'b1;
          end
        end
      end
      if (issue_fire) busy_d[sel_idx] = 1'b0;
      if (alloc_fire) begin
        busy_d[alloc_idx]   = 1'b1;
        pc_d[alloc_idx]     = bus.alloc_pc_i;
        imm_d[alloc_idx]    = bus.alloc_imm_i;
        tag_d[alloc_idx]    = bus.alloc_rrf_tag_i;
        dst_en_d[alloc_idx] = bus.alloc_dst_en_i;
        alu_op_d[alloc_idx] = bus.alloc_alu_op_i;
        op1_d[alloc_idx]    = bus.alloc_op1_i;
        v1_d[alloc_idx]     = bus.alloc_valid1_i;
        op2_d[alloc_idx]    = bus.alloc_op2_i;
        v2_d[alloc_idx]     = bus.alloc_valid2_i;
        if (!bus.alloc_valid1_i) begin
          lk = wb_lookup(bus.alloc_op1_i[TAG_W-1:0], bus.wb_valid_i, bus.wb_tag_i, bus.wb_data_i);
          if (lk[DATA_W]) begin
            op1_d[alloc_idx] = lk[DATA_W-1:0];
            v1_d[alloc_idx]  = 1'b1;
          end
        end
        if (!bus.alloc_valid2_i) begin
          lk = wb_lookup(bus.alloc_op2_i[TAG_W-1:0], bus.wb_valid_i, bus.wb_tag_i, bus.wb_data_i);
          if (lk[DATA_W]) begin
            op2_d[alloc_idx] = lk[DATA_W-1:0];
            v2_d[alloc_idx]  = 1'b1;
          end
        end
`ifdef RS_ALU_AGE_SELECT_EN
        // New entry is younger than every occupant; its column is cleared of stale history
        for (int i = 0; i < int'(ENTRIES); i++) age_d[i][alloc_idx] = 1'b0;
        age_d[alloc_idx] = busy_q;
`endif
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by busy, so it needs no reset
  always_ff @(posedge clk) begin
    v1_q     <= v1_d;
    v2_q     <= v2_d;
    dst_en_q <= dst_en_d;
    pc_q     <= pc_d;
    op1_q    <= op1_d;
    op2_q    <= op2_d;
    imm_q    <= imm_d;
    tag_q    <= tag_d;
    alu_op_q <= alu_op_d;
  end

`ifdef RS_ALU_AGE_SELECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  // Issue fields are zeroed whenever nothing is presented
  always_comb begin
    bus.issue_valid_o   = issue_valid;
    bus.issue_pc_o      = '0;
    bus.issue_op1_o     = '0;
    bus.issue_op2_o     = '0;
    bus.issue_imm_o     = '0;
    bus.issue_rrf_tag_o = '0;
    bus.issue_dst_en_o  = 1'b0;
    bus.issue_alu_op_o  = '0;
    if (issue_valid) begin
      bus.issue_pc_o      = pc_q[sel_idx];
      bus.issue_op1_o     = op1_q[sel_idx];
      bus.issue_op2_o     = op2_q[sel_idx];
      bus.issue_imm_o     = imm_q[sel_idx];
      bus.issue_rrf_tag_o = tag_q[sel_idx];
      bus.issue_dst_en_o  = dst_en_q[sel_idx];
      bus.issue_alu_op_o  = alu_op_q[sel_idx];
    end
  end

  assign bus.alloc_ready_o = alloc_ready;
  assign bus.count_o       = count_q;
endmodule

// File: tb/tb_rs_alu_multi.sv
// Directed bench for rs_alu_multi: a vector table plus hand sequences for
// fill/full, flush and select-order corners.
module tb_rs_alu_multi;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_alu_multi_if #(.ENTRIES(8), .DATA_W(32), .ADDR_W(32), .TAG_W(6), .ALUOP_W(4), .WB_PORTS(2)) bus ();

  rs_alu_multi #(.ENTRIES(8), .DATA_W(32), .ADDR_W(32), .TAG_W(6), .ALUOP_W(4), .WB_PORTS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        av;
    logic [31:0] pc, op1, op2;
    logic        v1, v2;
    logic [5:0]  tag;
    logic [1:0]  wbv;
    logic [5:0]  wt0, wt1;
    logic [31:0] wd0, wd1;
    logic        irdy, flush;
  } drv_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, op1, op2;
    logic [5:0]  tag;
    logic [3:0]  cnt;
    logic        ardy;
  } exp_t;

  typedef struct {
    drv_t d;
    exp_t e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[9];

  function automatic drv_t d_idle(input logic irdy);
    drv_t d;
    d = '{av: 1'b0, pc: '0, op1: '0, op2: '0, v1: 1'b0, v2: 1'b0, tag: '0,
          wbv: '0, wt0: '0, wt1: '0, wd0: '0, wd1: '0, irdy: irdy, flush: 1'b0};
    return d;
  endfunction

  function automatic drv_t d_alloc(input logic [31:0] pc, input logic [31:0] op1, input logic v1,
                                   input logic [31:0] op2, input logic v2, input logic [5:0] tag,
                                   input logic irdy);
    drv_t d;
    d = d_idle(irdy);
    d.av = 1'b1; d.pc = pc; d.op1 = op1; d.v1 = v1; d.op2 = op2; d.v2 = v2; d.tag = tag;
    return d;
  endfunction

  function automatic drv_t d_wb(input drv_t b, input int port, input logic [5:0] t, input logic [31:0] data);
    drv_t d;
    d = b;
    if (port == 0) begin d.wbv[0] = 1'b1; d.wt0 = t; d.wd0 = data; end
    else           begin d.wbv[1] = 1'b1; d.wt1 = t; d.wd1 = data; end
    return d;
  endfunction

  function automatic exp_t ex(input logic v, input logic [31:0] pc, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [5:0] tag, input logic [3:0] cnt,
                              input logic ardy);
    exp_t e;
    e = '{valid: v, pc: pc, op1: op1, op2: op2, tag: tag, cnt: cnt, ardy: ardy};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_exp(input string where, input exp_t e);
    chk({where, " issue_valid"}, 32'(bus.issue_valid_o), 32'(e.valid));
    chk({where, " issue_pc"},    bus.issue_pc_o,         e.pc);
    chk({where, " issue_op1"},   bus.issue_op1_o,        e.op1);
    chk({where, " issue_op2"},   bus.issue_op2_o,        e.op2);
    chk({where, " issue_tag"},   32'(bus.issue_rrf_tag_o), 32'(e.tag));
    chk({where, " count"},       32'(bus.count_o),       32'(e.cnt));
    chk({where, " alloc_ready"}, 32'(bus.alloc_ready_o), 32'(e.ardy));
  endtask

  // Drive one cycle of inputs, then settle just after the edge
  task automatic cycle(input drv_t d);
    bus.alloc_valid_i   = d.av;
    bus.alloc_pc_i      = d.pc;
    bus.alloc_op1_i     = d.op1;
    bus.alloc_op2_i     = d.op2;
    bus.alloc_valid1_i  = d.v1;
    bus.alloc_valid2_i  = d.v2;
    bus.alloc_imm_i     = d.pc ^ 32'h5;
    bus.alloc_rrf_tag_i = d.tag;
    bus.alloc_dst_en_i  = 1'b1;
    bus.alloc_alu_op_i  = d.tag[3:0];
    bus.wb_valid_i      = d.wbv;
    bus.wb_tag_i        = {d.wt1, d.wt0};
    bus.wb_data_i       = {d.wd1, d.wd0};
    bus.issue_ready_i   = d.irdy;
    bus.flush_i         = d.flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drv_t d;
    logic [31:0] first_pc, second_pc;

    tbl[0] = '{d: d_idle(1'b0), e: ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd0, 1'b1)};
    tbl[1] = '{d: d_alloc(32'h100, 32'd5, 1'b1, 32'd7, 1'b1, 6'h01, 1'b1),
               e: ex(1'b1, 32'h100, 32'd5, 32'd7, 6'h01, 4'd1, 1'b1)};
    tbl[2] = '{d: d_idle(1'b1), e: ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd0, 1'b1)};
    tbl[3] = '{d: d_alloc(32'h200, 32'h12, 1'b0, 32'd3, 1'b1, 6'h02, 1'b1),
               e: ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd1, 1'b1)};
    tbl[4] = '{d: d_idle(1'b1), e: ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd1, 1'b1)};
    tbl[5] = '{d: d_wb(d_idle(1'b0), 1, 6'h12, 32'hDEAD),
               e: ex(1'b1, 32'h200, 32'hDEAD, 32'd3, 6'h02, 4'd1, 1'b1)};
    tbl[6] = '{d: d_idle(1'b1), e: ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd0, 1'b1)};
    tbl[7] = '{d: d_wb(d_wb(d_alloc(32'h300, 32'h15, 1'b0, 32'd9, 1'b1, 6'h03, 1'b0),
                            0, 6'h15, 32'hBEEF), 1, 6'h15, 32'hCAFE),
               e: ex(1'b1, 32'h300, 32'hBEEF, 32'd9, 6'h03, 4'd1, 1'b1)};
    tbl[8] = '{d: d_idle(1'b1), e: ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd0, 1'b1)};

    reset = 1'b1;
    d = d_idle(1'b0);
    cycle(d);
    cycle(d);
    reset = 1'b0;
    chk_exp("reset", ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd0, 1'b1));

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].d);
      chk_exp($sformatf("vec%0d", i), tbl[i].e);
    end

    // Fill all entries with operands still waiting
    for (int i = 0; i < 8; i++) begin
      cycle(d_alloc(32'h400 + 32'(4*i), 32'h20 + 32'(i), 1'b0, 32'(i), 1'b1, 6'(16 + i), 1'b1));
      chk($sformatf("fill%0d count", i), 32'(bus.count_o), 32'(i + 1));
      chk($sformatf("fill%0d alloc_ready", i), 32'(bus.alloc_ready_o), (i < 7) ? 32'd1 : 32'd0);
    end
    cycle(d_alloc(32'h999, 32'd1, 1'b1, 32'd2, 1'b1, 6'h3F, 1'b1));
    chk_exp("full_extra", ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd8, 1'b0));
    cycle(d_wb(d_alloc(32'h999, 32'd1, 1'b1, 32'd2, 1'b1, 6'h3F, 1'b0), 0, 6'h23, 32'h33));
    chk_exp("full_wake", ex(1'b1, 32'h40C, 32'h33, 32'd3, 6'h13, 4'd8, 1'b0));
    cycle(d_alloc(32'h999, 32'd1, 1'b1, 32'd2, 1'b1, 6'h3F, 1'b1));
    chk_exp("full_fire", ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd7, 1'b1));

    // Flush, refill to five, then flush alongside an allocation
    d = d_idle(1'b0);
    d.flush = 1'b1;
    cycle(d);
    chk_exp("flush_clear", ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd0, 1'b1));
    for (int i = 0; i < 5; i++)
      cycle(d_alloc(32'h500 + 32'(4*i), 32'h28 + 32'(i), 1'b0, 32'd0, 1'b1, 6'(i), 1'b1));
    chk("mid count", 32'(bus.count_o), 32'd5);
    d = d_alloc(32'h777, 32'd1, 1'b1, 32'd2, 1'b1, 6'h0A, 1'b1);
    d.flush = 1'b1;
    cycle(d);
    chk_exp("flush_alloc", ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd0, 1'b1));
    cycle(d_idle(1'b1));
    chk_exp("flush_after", ex(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 4'd0, 1'b1));

    // Select order: A in entry 3, entry 0 freed and refilled by younger B
    cycle(d_alloc(32'h800, 32'h20, 1'b0, 32'd0, 1'b1, 6'h00, 1'b0));
    cycle(d_alloc(32'h804, 32'h21, 1'b0, 32'd0, 1'b1, 6'h01, 1'b0));
    cycle(d_alloc(32'h808, 32'h22, 1'b0, 32'd0, 1'b1, 6'h02, 1'b0));
    cycle(d_alloc(32'h80C, 32'h30, 1'b0, 32'd0, 1'b1, 6'h03, 1'b0));
    cycle(d_wb(d_idle(1'b0), 0, 6'h20, 32'h1));
    chk("age e0 valid", 32'(bus.issue_valid_o), 32'd1);
    chk("age e0 pc", bus.issue_pc_o, 32'h800);
    cycle(d_idle(1'b1));
    chk("age free count", 32'(bus.count_o), 32'd3);
    cycle(d_alloc(32'h900, 32'h31, 1'b0, 32'd0, 1'b1, 6'h04, 1'b1));
    chk("age b count", 32'(bus.count_o), 32'd4);
    chk("age b not ready", 32'(bus.issue_valid_o), 32'd0);
    cycle(d_wb(d_wb(d_idle(1'b0), 0, 6'h30, 32'hA), 1, 6'h31, 32'hB));
`ifdef RS_ALU_AGE_SELECT_EN
    first_pc = 32'h80C; second_pc = 32'h900;
`else
    first_pc = 32'h900; second_pc = 32'h80C;
`endif
    chk("order first pc", bus.issue_pc_o, first_pc);
    cycle(d_idle(1'b1));
    chk("order second pc", bus.issue_pc_o, second_pc);
    cycle(d_idle(1'b1));
    chk("order done valid", 32'(bus.issue_valid_o), 32'd0);
    chk("order done count", 32'(bus.count_o), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rs_alu_multi.md
# rs_alu_multi

Parametrised multi-entry ALU reservation station for the out-of-order core's ALU issue path. It sits between dispatch and the ALU execution unit. It buffers up to ENTRIES renamed ALU instructions and captures missing source operands from WB_PORTS writeback/forwarding buses. Each cycle it issues one ready instruction to the ALU under a valid/ready handshake.

## Interface
- ENTRIES, 8: station depth, power of two, ≥2
- DATA_W, 32: operand/immediate width
- ADDR_W, 32: PC width
- TAG_W, 6: RRF tag width; must be ≤ DATA_W
- ALUOP_W, 4: ALU opcode width
- WB_PORTS, 2: number of wakeup broadcast ports
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  squash all entries (branch mispredict)
- alloc_valid_i  in  1  dispatch presents an instruction
- alloc_ready_o  out  1  at least one free entry
- alloc_pc_i  in  ADDR_W  instruction PC
- alloc_op1_i, alloc_op2_i  in  DATA_W  operand value, or source tag in [TAG_W-1:0] when not valid
- alloc_valid1_i, alloc_valid2_i  in  1  operand holds a value
- alloc_imm_i  in  DATA_W  immediate
- alloc_rrf_tag_i  in  TAG_W  destination RRF tag
- alloc_dst_en_i  in  1  instruction writes a destination
- alloc_alu_op_i  in  ALUOP_W  ALU operation
- wb_valid_i  in  WB_PORTS  per-port broadcast valid
- wb_tag_i  in  WB_PORTS*TAG_W  broadcast tags, port p at [p*TAG_W +: TAG_W]
- wb_data_i  in  WB_PORTS*DATA_W  broadcast data
- issue_valid_o  out  1  a ready entry is presented
- issue_ready_i  in  1  ALU accepts
- issue_pc_o, issue_op1_o, issue_op2_o, issue_imm_o, issue_rrf_tag_o, issue_dst_en_o, issue_alu_op_o  out  as alloc  issued fields
- count_o  out  $clog2(ENTRIES)+1  occupied entries

## Operation
- Entry state: busy, pc, op1/op2, valid1/valid2, imm, rrf_tag, dst_en, alu_op.
- Allocation (alloc_valid_i && alloc_ready_o): write into the lowest-index free entry and set busy.
- Wakeup: for every busy entry and every invalid operand, if wb_valid_i[p] and wb_tag_i[p] equals op[TAG_W-1:0], latch wb_data_i[p] and set valid. If several ports match, the lowest p wins.
- Allocation bypass: an operand arriving invalid whose tag matches a broadcast in the same cycle is written already valid with the broadcast data.
- Ready = busy && valid1 && valid2. Select picks one ready entry (see Configuration).
- Issue outputs are combinational from the selected entry.
  - issue_valid_o = any ready.
  - Fields are driven to 0 when issue_valid_o=0.
- Issue fire (issue_valid_o && issue_ready_i): clear busy of the selected entry at the edge.
- count_o next = count + alloc_fire − issue_fire. It is held in a register.
- Priority: reset > flush_i > alloc/issue/wakeup. flush_i clears all busy bits and age state; alloc and issue in that cycle are ignored.

## Timing
- Reset values: all busy=0, issue_valid_o=0, all issue fields 0, alloc_ready_o=1, count_o=0.
- alloc_ready_o derives from registered busy bits only. An entry freed by issue at edge t is allocatable from cycle t+1. With the station full, alloc_ready_o=0 even in a cycle that issues.
- Allocate-to-issue latency: an entry allocated fully valid at edge t can assert issue_valid_o in the cycle after t (1 cycle).
- Wakeup latency: a broadcast in cycle t makes the operand valid after edge t, so the entry can issue in cycle t+1.
- The same entry is never issued twice. Allocation never targets an entry freed in the same cycle.
- If issue_ready_i=0, the selection may change when an older entry becomes ready. The ALU samples fields only on fire.

## Configuration
- RS_ALU_AGE_SELECT_EN defined: oldest-first select. An ENTRIES×ENTRIES age matrix is updated on allocation: the new entry is younger than all busy entries. Issue picks the ready entry with no older ready entry.
- Not defined: fixed-priority select of the lowest-index ready entry. No age state is kept.

## Test plan
- Reset, then idle: alloc_ready_o=1, count_o=0, issue_valid_o=0, all issue fields 0.
- Allocate pc=0x100, op1=5, op2=7 both valid, issue_ready_i=1: issue_valid_o=1 the next cycle with op1=5, op2=7; count_o returns to 0 after the fire.
- Allocate op1 invalid, tag 0x12. Two cycles later, broadcast wb port 1 tag 0x12, data 0xDEAD: issue in the following cycle with op1=0xDEAD. A broadcast of the same tag coincident with allocation gives ready the next cycle.
- Fill 8 entries, all invalid: alloc_ready_o=0 and count_o=8; an extra alloc_valid_i is ignored. Wake one entry and issue it: alloc_ready_o=1 one cycle after the fire.
- With RS_ALU_AGE_SELECT_EN: allocate A into entry 3, free entry 0, then allocate B into entry 0, and wake both in the same cycle. A issues first. Without the macro, B issues first.
- Mid-occupancy (count_o=5), assert flush_i together with alloc_valid_i: next cycle count_o=0, issue_valid_o=0, and no entry is allocated.
